frv_fetch_align_buffer: RTL

Halfword-granular instruction buffer between the fetch memory interface and the decode stage pipeline register. It accepts 32-bit fetch words, splits them into 16-bit parcels and emits whole 16-bit (compressed) or 32-bit instructions with valid/busy handshakes on both sides. It re-aligns 32-bit instructions that straddle two fetch words. On a control-flow change it flushes, with optional discard of the low halfword for halfword-aligned targets.

---
 rtl/frv_fetch_align_buffer_pkg.sv | 15 +
 rtl/frv_fetch_align_buffer.sv | 104 ++++++++++
 2 files changed

// File: rtl/frv_fetch_align_buffer_pkg.sv
// rtl/frv_fetch_align_buffer_pkg.sv - shared parcel type and instruction-length helpers
package frv_fetch_align_buffer_pkg;

  localparam logic [1:0] FRV_OPC_LEN32 = 2'b11;

  typedef struct packed {
    logic [15:0] hw;
    logic        err;
  } frv_parcel_t;

  function automatic logic frv_is_c(input logic [15:0] hw);
    return hw[1:0] != FRV_OPC_LEN32;
  endfunction

endpackage

// File: rtl/frv_fetch_align_buffer.sv
// rtl/frv_fetch_align_buffer.sv - halfword re-aligning buffer between fetch and decode
module frv_fetch_align_buffer
  import frv_fetch_align_buffer_pkg::*;
#(
  parameter int BUF_HW = 4
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic [31:0] i_data,
  input  logic        i_err,
  input  logic        i_valid,
  output logic        o_busy,
  input  logic        flush,
  input  logic        flush_hw,
  output logic [31:0] o_data,
  output logic        o_c,
  output logic        o_err,
  output logic        o_valid,
  input  logic        i_busy
);

  // Wide enough for slot index + pop count without wrapping.
  localparam int CW = $clog2(BUF_HW + 3);
  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [CW-1:0] TWO = CW'(2);

  frv_parcel_t   slot_q [BUF_HW];
  frv_parcel_t   slot_d [BUF_HW];
  logic [CW-1:0] count_q, count_d;
  logic          drop_lo_q, drop_lo_d;

  logic          s0_c;
  logic          push, pop;
  logic [CW-1:0] push_n, pop_n, keep_n;
  frv_parcel_t   lo_p, hi_p;

  always_comb begin
    s0_c    = frv_is_c(slot_q[0].hw);
    o_busy  = count_q > CW'(BUF_HW - 2);
    o_valid = (count_q >= TWO) || ((count_q == ONE) && (s0_c || slot_q[0].err));
    o_c     = o_valid && (s0_c || (count_q == ONE));
    o_data  = 32'h0;
    o_err   = 1'b0;
    if (o_valid && o_c) begin
      o_data = {16'h0, slot_q[0].hw};
      o_err  = slot_q[0].err;
    end else if (o_valid) begin
      o_data = {slot_q[1].hw, slot_q[0].hw};
      o_err  = slot_q[0].err | slot_q[1].err;
    end
  end

  always_comb begin
    push   = i_valid && !o_busy && !flush;
    pop    = o_valid && !i_busy;
    pop_n  = pop ? (o_c ? ONE : TWO) : '0;
    push_n = push ? (drop_lo_q ? ONE : TWO) : '0;
    keep_n = count_q - pop_n;
    lo_p   = {i_data[15:0], i_err};
    hi_p   = {i_data[31:16], i_err};

    for (int i = 0; i < BUF_HW; i++) begin
      slot_d[i] = slot_q[i];
    end
    count_d   = keep_n + push_n;
    drop_lo_d = push ? 1'b0 : drop_lo_q;

    // Survivors slide down by pop_n; new parcels append right after them.
    for (int i = 0; i < BUF_HW; i++) begin
      if (CW'(i) + pop_n < count_q) begin
        for (int j = 0; j < BUF_HW; j++) begin
          if (CW'(j) == CW'(i) + pop_n) slot_d[i] = slot_q[j];
        end
      end else if ((CW'(i) >= keep_n) && (CW'(i) < keep_n + push_n)) begin
        slot_d[i] = (drop_lo_q || (CW'(i) != keep_n)) ? hi_p : lo_p;
      end
    end

    if (flush) begin
      for (int i = 0; i < BUF_HW; i++) begin
        slot_d[i] = slot_q[i];
      end
      count_d   = '0;
      drop_lo_d = flush_hw;
    end
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      for (int i = 0; i < BUF_HW; i++) begin
        slot_q[i] <= '0;
      end
      count_q   <= '0;
      drop_lo_q <= 1'b0;
    end else begin
      for (int i = 0; i < BUF_HW; i++) begin
        slot_q[i] <= slot_d[i];
      end
      count_q   <= count_d;
      drop_lo_q <= drop_lo_d;
    end
  end

endmodule
